norm_phase_seq: RTL and testbench

- Normal-mode signal sequencer. Generates the per-lane green grants allow_0_norm..allow_3_norm that the traffic control unit forwards to the lights while in NORMAL mode.
- Runs round-robin green phases with an all-red clearance interval between them. Skips lanes with no demand and ends a green early (gap-out) once its lane empties.
- Enabled and paced by the control unit's norm_op_en and norm_counter_en.

---
 rtl/norm_phase_seq.sv | 145 ++++++++++++++
 tb/tb_norm_phase_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_phase_seq.sv
// Normal-mode sequencer: round-robin green phases with all-red clearance,
// demand-based lane skipping and gap-out once the served lane empties.
module norm_phase_seq #(
    parameter int GREEN_CYC = 20,
    parameter int MIN_GREEN = 5,
    parameter int CLEAR_CYC = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       norm_op_en,
    input  logic       norm_counter_en,
    input  logic       car_present_0,
    input  logic       car_present_1,
    input  logic       car_present_2,
    input  logic       car_present_3,
    output logic       allow_0_norm,
    output logic       allow_1_norm,
    output logic       allow_2_norm,
    output logic       allow_3_norm,
    output logic [1:0] phase_idx,
    output logic       phase_done
);

    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

    typedef enum logic [1:0] {IDLE, GREEN, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       allow_q, allow_d;
    logic [1:0]       phase_idx_q, phase_idx_d;
    logic             phase_done_q, phase_done_d;

    logic [3:0] car;
    logic [1:0] sel;
    logic       green_end;
    logic       clear_end;

    assign car = {car_present_3, car_present_2, car_present_1, car_present_0};

    // Walk the offsets from farthest to nearest so the nearest demanding lane
    // after phase_idx wins; with no demand the +1 default falls out naturally.
    always_comb begin
        sel = phase_idx_q + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            if (car[phase_idx_q + 2'(k)]) sel = phase_idx_q + 2'(k);
        end
    end

    assign green_end = (cnt_q == GREEN_LAST) ||
                       (!car[phase_idx_q] && (cnt_q >= MIN_LAST));
    assign clear_end = (cnt_q == CLEAR_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!norm_op_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = GREEN;
                GREEN:   if (norm_counter_en && green_end) state_d = CLEAR;
                CLEAR:   if (norm_counter_en && clear_end) state_d = GREEN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered datapath and outputs
    always_comb begin
        cnt_d        = cnt_q;
        allow_d      = allow_q;
        phase_idx_d  = phase_idx_q;
        phase_done_d = 1'b0;
        if (!norm_op_en) begin
            cnt_d   = '0;
            allow_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    phase_idx_d = sel;
                    allow_d     = 4'(1) << sel;
                    cnt_d       = '0;
                end
                GREEN: begin
                    if (norm_counter_en) begin
                        if (green_end) begin
                            cnt_d   = '0;
                            allow_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (norm_counter_en) begin
                        if (clear_end) begin
                            phase_idx_d  = sel;
                            allow_d      = 4'(1) << sel;
                            cnt_d        = '0;
                            phase_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_d   = '0;
                    allow_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            allow_q      <= '0;
            phase_idx_q  <= 2'd3;
            phase_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            allow_q      <= allow_d;
            phase_idx_q  <= phase_idx_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign allow_0_norm = allow_q[0];
    assign allow_1_norm = allow_q[1];
    assign allow_2_norm = allow_q[2];
    assign allow_3_norm = allow_q[3];
    assign phase_idx    = phase_idx_q;
    assign phase_done   = phase_done_q;

endmodule

// File: tb/tb_norm_phase_seq.sv
// Bench for norm_phase_seq: a cycle model pushes expected outputs into a
// queue on every driven cycle; directed phase-length checks use the constants.
module tb_norm_phase_seq;

    localparam int G  = 20;
    localparam int MN = 5;
    localparam int C  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_en = 1'b0;
    logic       cen = 1'b0;
    logic [3:0] car = 4'b0;
    logic       a0, a1, a2, a3, done;
    logic [1:0] idx;
    logic [3:0] allow_v;

    assign allow_v = {a3, a2, a1, a0};

    always #5 clk = ~clk;

    norm_phase_seq #(.GREEN_CYC(G), .MIN_GREEN(MN), .CLEAR_CYC(C), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .norm_op_en(op_en), .norm_counter_en(cen),
        .car_present_0(car[0]), .car_present_1(car[1]),
        .car_present_2(car[2]), .car_present_3(car[3]),
        .allow_0_norm(a0), .allow_1_norm(a1), .allow_2_norm(a2), .allow_3_norm(a3),
        .phase_idx(idx), .phase_done(done)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [3:0] allow;
        logic [1:0] idx;
        logic       done;
    } exp_t;
    exp_t sb[$];

    // Reference model: 0 idle, 1 green, 2 clear
    int         m_st;
    int         m_cnt;
    logic [1:0] m_idx;
    logic [3:0] m_allow;
    logic       m_done;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_sel();
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (int'(m_idx) + k) % 4;
            if (car[j]) return 2'(j);
        end
        return 2'((int'(m_idx) + 1) % 4);
    endfunction

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_idx = 2'd3; m_allow = 4'b0; m_done = 1'b0;
    endtask

    task automatic m_tick();
        logic [1:0] s;
        s = m_sel();
        m_done = 1'b0;
        if (!op_en) begin
            m_st = 0; m_cnt = 0; m_allow = 4'b0;
        end else if (m_st == 0) begin
            m_st = 1; m_idx = s; m_allow = 4'(1) << s; m_cnt = 0;
        end else if (cen) begin
            if (m_st == 1) begin
                if (m_cnt == G - 1 || (!car[m_idx] && m_cnt >= MN - 1)) begin
                    m_st = 2; m_cnt = 0; m_allow = 4'b0;
                end else m_cnt++;
            end else begin
                if (m_cnt == C - 1) begin
                    m_st = 1; m_idx = s; m_allow = 4'(1) << s; m_cnt = 0; m_done = 1'b1;
                end else m_cnt++;
            end
        end
    endtask

    // One clock: model predicts, DUT advances, oldest expectation is compared.
    task automatic step();
        exp_t e;
        m_tick();
        sb.push_back('{allow: m_allow, idx: m_idx, done: m_done});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("allow", int'(allow_v), int'(e.allow));
        chk("phase_idx", int'(idx), int'(e.idx));
        chk("phase_done", int'(done), int'(e.done));
        chk("onehot", int'($countones(allow_v) <= 1), 1);
    endtask

    task automatic do_reset();
        op_en = 1'b0; cen = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        sb.delete();
        chk("rst_allow", int'(allow_v), 0);
        chk("rst_idx", int'(idx), 3);
        chk("rst_done", int'(done), 0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_green(input int lane, output int n);
        n = 0;
        while (allow_v[lane] && n < 200) begin step(); n++; end
    endtask

    task automatic run_clear(output int n);
        n = 0;
        while (allow_v == 4'b0 && n < 200) begin step(); n++; end
    endtask

    initial begin
        int n, k;
        m_reset();
        #12;
        chk("init_allow", int'(allow_v), 0);
        chk("init_idx", int'(idx), 3);
        chk("init_done", int'(done), 0);
        rst_n = 1'b1;

        // Full demand: 0,1,2,3,0 each for GREEN_CYC with CLEAR_CYC between
        do_reset();
        car = 4'hF; op_en = 1'b1; cen = 1'b1;
        step();
        chk("s1_first", int'(allow_v), 1);
        for (int l = 0; l < 4; l++) begin
            run_green(l, n);
            chk("s1_green_len", n, G);
            run_clear(n);
            chk("s1_clear_len", n, C);
            chk("s1_next_lane", int'(allow_v), 1 << ((l + 1) % 4));
            chk("s1_done", int'(done), 1);
        end

        // Only lane 2 demands: re-granted after clearance
        do_reset();
        car = 4'b0100; op_en = 1'b1; cen = 1'b1;
        step();
        chk("s2_idx", int'(idx), 2);
        run_green(2, n);
        chk("s2_green_len", n, G);
        run_clear(n);
        chk("s2_clear_len", n, C);
        chk("s2_regrant", int'(allow_v), 4);

        // Gap-out: demand drops during green cycle 2 -> MIN_GREEN cycles
        do_reset();
        car = 4'hF; op_en = 1'b1; cen = 1'b1;
        step();
        step();
        car[0] = 1'b0;
        run_green(0, n);
        chk("s3_gap_min", n + 1, MN);
        // Demand drops during green cycle 8 -> green ends after cycle 8
        do_reset();
        car = 4'hF; op_en = 1'b1; cen = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        car[0] = 1'b0;
        run_green(0, n);
        chk("s3_gap_late", n + 7, 8);
        run_clear(n);
        chk("s3_gap_clear", n, C);

        // Stall 10 cycles mid-green on lane 1
        do_reset();
        car = 4'hF; op_en = 1'b1; cen = 1'b1;
        step();
        run_green(0, n);
        run_clear(n);
        chk("s4_lane1", int'(allow_v), 2);
        k = 0;
        for (int i = 0; i < 4; i++) begin step(); k++; end
        cen = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); k++; end
        cen = 1'b1;
        run_green(1, n);
        chk("s4_stall_len", n + k, G + 10);
        run_clear(n);
        chk("s4_clear_len", n, C);

        // Enable dropped during lane-1 green, then re-enabled
        do_reset();
        car = 4'hF; op_en = 1'b1; cen = 1'b1;
        step();
        run_green(0, n);
        run_clear(n);
        step(); step();
        op_en = 1'b0;
        step();
        chk("s5_off_allow", int'(allow_v), 0);
        chk("s5_off_idx", int'(idx), 1);
        step(); step();
        op_en = 1'b1;
        step();
        chk("s5_reen", int'(allow_v), 4);

        // No demand: rotate with MIN_GREEN greens, then async reset mid-green
        do_reset();
        car = 4'b0; op_en = 1'b1; cen = 1'b1;
        step();
        for (int l = 0; l < 4; l++) begin
            run_green(l, n);
            chk("s6_green_len", n, MN);
            run_clear(n);
            chk("s6_clear_len", n, C);
        end
        chk("s6_wrap", int'(allow_v), 1);
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_allow", int'(allow_v), 0);
        chk("s6_rst_idx", int'(idx), 3);
        sb.delete();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
